// File: rtl/am_inference_ctrl.sv
// rtl/am_inference_ctrl.sv - associative-memory inference sequencer with argmax tracking (optional margin output: AM_CTRL_MARGIN_EN)
module am_inference_ctrl #(
    parameter int NUM_CLASSES   = 26,
    parameter int CHUNKS_PER_HV = 10,
    parameter int SIM_W         = 13,
    parameter int CLASS_W       = 5,
    parameter int CHUNK_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [CLASS_W-1:0] class_addr,
    output logic [CHUNK_W-1:0] chunk_addr,
    output logic               comparing_query_hv_with_class_hv,
    output logic               inferring_class,
    input  logic [SIM_W-1:0]   similarity_value,
    output logic [CLASS_W-1:0] predicted_class,
    output logic [SIM_W-1:0]   best_similarity
`ifdef AM_CTRL_MARGIN_EN
    ,
    output logic [SIM_W-1:0]   margin
`endif
);

    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS_PER_HV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPARE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [CLASS_W-1:0] r_class;
    logic [CHUNK_W-1:0] r_chunk;
    logic               r_cmp;
    logic               r_infer;
    logic [CLASS_W-1:0] r_pred;
    logic [SIM_W-1:0]   r_best;

    logic               w_take_new;
    logic [SIM_W-1:0]   w_best_next;

`ifdef AM_CTRL_MARGIN_EN
    logic [SIM_W-1:0]   r_second;
    logic [SIM_W-1:0]   r_margin;
    logic [SIM_W-1:0]   w_second_next;
`endif

    // Argmax decision for the class being evaluated; class 0 always seeds the running best,
    // and a tie keeps the earlier (lower) index.
    always_comb begin
        w_take_new  = (r_class == '0) || (similarity_value > r_best);
        w_best_next = w_take_new ? similarity_value : r_best;
    end

`ifdef AM_CTRL_MARGIN_EN
    // Runner-up tracking: a displaced best becomes the runner-up; values equal to the
    // current best are treated as the same score and never become the runner-up.
    always_comb begin
        w_second_next = r_second;
        if (r_class == '0) begin
            w_second_next = '0;
        end else if (similarity_value > r_best) begin
            w_second_next = r_best;
        end else if ((similarity_value < r_best) && (similarity_value > r_second)) begin
            w_second_next = similarity_value;
        end
    end
`endif

    // Sequencer FSM with all outputs registered; accumulate enable trails COMPARE by the AM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_class  <= '0;
            r_chunk  <= '0;
            r_cmp    <= 1'b0;
            r_infer  <= 1'b0;
            r_pred   <= '0;
            r_best   <= '0;
`ifdef AM_CTRL_MARGIN_EN
            r_second <= '0;
            r_margin <= '0;
`endif
        end else begin
            r_cmp <= (r_state == S_COMPARE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_class <= '0;
                        r_chunk <= '0;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_COMPARE;
                    r_chunk <= '0;
                end
                S_COMPARE: begin
                    if (r_chunk == LAST_CHUNK) begin
                        r_chunk <= '0;
                        r_infer <= 1'b1;
                        r_state <= S_WAIT;
                    end else begin
                        r_chunk <= r_chunk + CHUNK_W'(1);
                    end
                end
                S_WAIT: begin
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_infer <= 1'b0;
                    r_best  <= w_best_next;
                    if (w_take_new) begin
                        r_pred <= r_class;
                    end
`ifdef AM_CTRL_MARGIN_EN
                    r_second <= w_second_next;
`endif
                    if (r_class == LAST_CLASS) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`ifdef AM_CTRL_MARGIN_EN
                        r_margin <= w_best_next - w_second_next;
`endif
                    end else begin
                        r_class <= r_class + CLASS_W'(1);
                        r_state <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                             = r_busy;
    assign done                             = r_done;
    assign class_addr                       = r_class;
    assign chunk_addr                       = r_chunk;
    assign comparing_query_hv_with_class_hv = r_cmp;
    assign inferring_class                  = r_infer;
    assign predicted_class                  = r_pred;
    assign best_similarity                  = r_best;
`ifdef AM_CTRL_MARGIN_EN
    assign margin                           = r_margin;
`endif

endmodule

// File: tb/tb_am_inference_ctrl.sv
// tb/tb_am_inference_ctrl.sv - self-checking bench for am_inference_ctrl (default and 3-class builds)
module tb_am_inference_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    // default-parameter instance
    logic        d_start, d_busy, d_done, d_cmp, d_inf;
    logic [4:0]  d_class_addr, d_pred;
    logic [3:0]  d_chunk_addr;
    logic [12:0] d_sim, d_best;
    // 3 classes x 2 chunks instance
    logic        s_start, s_busy, s_done, s_cmp, s_inf;
    logic [1:0]  s_class_addr, s_pred;
    logic [0:0]  s_chunk_addr;
    logic [12:0] s_sim, s_best;
`ifdef AM_CTRL_MARGIN_EN
    logic [12:0] d_margin, s_margin;
`endif

    am_inference_ctrl u_dut (
        .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
        .class_addr(d_class_addr), .chunk_addr(d_chunk_addr),
        .comparing_query_hv_with_class_hv(d_cmp), .inferring_class(d_inf),
        .similarity_value(d_sim), .predicted_class(d_pred), .best_similarity(d_best)
`ifdef AM_CTRL_MARGIN_EN
        , .margin(d_margin)
`endif
    );

    am_inference_ctrl #(.NUM_CLASSES(3), .CHUNKS_PER_HV(2), .SIM_W(13), .CLASS_W(2), .CHUNK_W(1)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .class_addr(s_class_addr), .chunk_addr(s_chunk_addr),
        .comparing_query_hv_with_class_hv(s_cmp), .inferring_class(s_inf),
        .similarity_value(s_sim), .predicted_class(s_pred), .best_similarity(s_best)
`ifdef AM_CTRL_MARGIN_EN
        , .margin(s_margin)
`endif
    );

    // AM rows (per-chunk popcounts of query AND class) plus tree adder environment models
    int          d_contrib [0:25][0:9];
    int          s_contrib [0:2][0:1];
    logic [12:0] d_rdata, s_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata <= '0; d_sim <= '0; s_rdata <= '0; s_sim <= '0;
        end else begin
            d_rdata <= (d_class_addr < 5'd26 && d_chunk_addr < 4'd10) ? 13'(d_contrib[d_class_addr][d_chunk_addr]) : '0;
            s_rdata <= (s_class_addr < 2'd3) ? 13'(s_contrib[s_class_addr][s_chunk_addr]) : '0;
            if (d_cmp) d_sim <= d_sim + d_rdata; else if (!d_inf) d_sim <= '0;
            if (s_cmp) s_sim <= s_sim + s_rdata; else if (!s_inf) s_sim <= '0;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    bit d_start_at [0:800];
    bit d_cmp_h [0:800];
    bit d_inf_h [0:800];
    bit d_busy_h [0:800];
    int d_chunk_h [0:800];
    int d_class_h [0:800];
    int d_margin_done;

    // Starts at cycle 0 (sampled at edge 0), extra start pulses from d_start_at; cycle k follows edge k-1.
    task automatic d_run(input int limit, output int first_done, output int second_done, output int n_done);
        first_done = -1; second_done = -1; n_done = 0; d_margin_done = -1;
        @(negedge clk);
        d_start = 1'b1;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            d_start        = d_start_at[cyc];
            d_cmp_h[cyc]   = d_cmp;
            d_inf_h[cyc]   = d_inf;
            d_busy_h[cyc]  = d_busy;
            d_chunk_h[cyc] = int'(d_chunk_addr);
            d_class_h[cyc] = int'(d_class_addr);
            if (d_done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = cyc;
`ifdef AM_CTRL_MARGIN_EN
                    d_margin_done = int'(d_margin);
`endif
                end else begin
                    second_done = cyc;
                end
            end
        end
        d_start = 1'b0;
        for (int i = 0; i <= 800; i++) d_start_at[i] = 1'b0;
    endtask

    task automatic s_run(output int done_cyc, output int n_done, output int margin_at_done);
        done_cyc = -1; n_done = 0; margin_at_done = -1;
        @(negedge clk);
        s_start = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
`ifdef AM_CTRL_MARGIN_EN
                margin_at_done = int'(s_margin);
`endif
            end
        end
    endtask

    typedef struct {
        int s0, s1, s2;
        int exp_pred, exp_best, exp_margin;
    } vec_t;
    vec_t vecs [8];

    int fd, sd, nd, mg;
    int tot [26];
    int m_best, m_pred, m_second;

    initial begin
        vecs[0] = '{40, 75, 75, 1, 75, 35};
        vecs[1] = '{100, 300, 250, 1, 300, 50};
        vecs[2] = '{90, 90, 90, 0, 90, 90};
        vecs[3] = '{0, 0, 0, 0, 0, 0};
        vecs[4] = '{1000, 999, 1000, 0, 1000, 1};
        vecs[5] = '{5, 7, 9, 2, 9, 2};
        vecs[6] = '{9, 7, 5, 0, 9, 2};
        vecs[7] = '{3, 1000, 1000, 1, 1000, 997};
        for (int i = 0; i <= 800; i++) d_start_at[i] = 1'b0;

        // reset state
        rst = 1'b1; d_start = 1'b0; s_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(d_busy), 0);
        chk("rst_done", int'(d_done), 0);
        chk("rst_class_addr", int'(d_class_addr), 0);
        chk("rst_chunk_addr", int'(d_chunk_addr), 0);
        chk("rst_cmp", int'(d_cmp), 0);
        chk("rst_inf", int'(d_inf), 0);
        chk("rst_pred", int'(d_pred), 0);
        chk("rst_best", int'(d_best), 0);
        chk("rst_small_busy", int'(s_busy), 0);
`ifdef AM_CTRL_MARGIN_EN
        chk("rst_margin", int'(d_margin), 0);
`endif
        rst = 1'b0;

        // nominal: class 17 all-ones, others half-ones
        for (int c = 0; c < 26; c++)
            for (int k = 0; k < 10; k++) d_contrib[c][k] = (c == 17) ? 500 : 250;
        d_run(345, fd, sd, nd);
        chk("nom_done_cycle", fd, 339);
        chk("nom_done_count", nd, 1);
        chk("nom_pred", int'(d_pred), 17);
        chk("nom_best", int'(d_best), 5000);
`ifdef AM_CTRL_MARGIN_EN
        chk("nom_margin", d_margin_done, 2500);
`endif
        chk("cmp_cycle2", int'(d_cmp_h[2]), 0);
        for (int c = 3; c <= 12; c++) chk($sformatf("cmp_cycle%0d", c), int'(d_cmp_h[c]), 1);
        chk("inf_cycle11", int'(d_inf_h[11]), 0);
        chk("inf_cycle12", int'(d_inf_h[12]), 1);
        chk("inf_cycle13", int'(d_inf_h[13]), 1);
        chk("cmp_cycle14", int'(d_cmp_h[14]), 0);
        chk("inf_cycle14", int'(d_inf_h[14]), 0);
        chk("chunk_cycle2", d_chunk_h[2], 0);
        chk("chunk_cycle11", d_chunk_h[11], 9);
        chk("class_cycle13", d_class_h[13], 0);
        chk("class_cycle14", d_class_h[14], 1);
        chk("busy_cycle1", int'(d_busy_h[1]), 1);
        chk("busy_cycle339", int'(d_busy_h[339]), 1);
        chk("busy_cycle340", int'(d_busy_h[340]), 0);
        chk("pred_held", int'(d_pred), 17);

        // start while busy is ignored; start in IDLE at 340 begins a new run
        d_start_at[1] = 1'b1; d_start_at[50] = 1'b1; d_start_at[338] = 1'b1; d_start_at[340] = 1'b1;
        d_run(690, fd, sd, nd);
        chk("busy_start_first_done", fd, 339);
        chk("busy_start_second_done", sd, 679);
        chk("busy_start_done_count", nd, 2);

        // table vectors on the 3-class instance
        for (int v = 0; v < 8; v++) begin
            s_contrib[0][0] = vecs[v].s0 / 2; s_contrib[0][1] = vecs[v].s0 - vecs[v].s0 / 2;
            s_contrib[1][0] = vecs[v].s1 / 2; s_contrib[1][1] = vecs[v].s1 - vecs[v].s1 / 2;
            s_contrib[2][0] = vecs[v].s2 / 2; s_contrib[2][1] = vecs[v].s2 - vecs[v].s2 / 2;
            s_run(fd, nd, mg);
            chk($sformatf("vec%0d_done_cycle", v), fd, 16);
            chk($sformatf("vec%0d_done_count", v), nd, 1);
            chk($sformatf("vec%0d_pred", v), int'(s_pred), vecs[v].exp_pred);
            chk($sformatf("vec%0d_best", v), int'(s_best), vecs[v].exp_best);
`ifdef AM_CTRL_MARGIN_EN
            chk($sformatf("vec%0d_margin", v), mg, vecs[v].exp_margin);
`endif
        end

        // randomized runs against an argmax reference model
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 26; c++) begin
                if (c > 0 && $urandom_range(0, 3) == 0) begin
                    int src;
                    src = $urandom_range(0, c - 1);
                    for (int k = 0; k < 10; k++) d_contrib[c][k] = d_contrib[src][k];
                end else begin
                    for (int k = 0; k < 10; k++) d_contrib[c][k] = $urandom_range(0, 500);
                end
            end
            m_best = -1; m_pred = 0; m_second = 0;
            for (int c = 0; c < 26; c++) begin
                tot[c] = 0;
                for (int k = 0; k < 10; k++) tot[c] += d_contrib[c][k];
                if (tot[c] > m_best) begin m_best = tot[c]; m_pred = c; end
            end
            for (int c = 0; c < 26; c++)
                if (tot[c] < m_best && tot[c] > m_second) m_second = tot[c];
            d_run(342, fd, sd, nd);
            chk($sformatf("rnd%0d_done_cycle", r), fd, 339);
            chk($sformatf("rnd%0d_pred", r), int'(d_pred), m_pred);
            chk($sformatf("rnd%0d_best", r), int'(d_best), m_best);
`ifdef AM_CTRL_MARGIN_EN
            chk($sformatf("rnd%0d_margin", r), d_margin_done, m_best - m_second);
`endif
        end

        // reset in the middle of COMPARE for class 5
        for (int c = 0; c < 26; c++)
            for (int k = 0; k < 10; k++) d_contrib[c][k] = (c == 3) ? 400 : 100;
        @(negedge clk);
        d_start = 1'b1;
        for (int cyc = 1; cyc <= 71; cyc++) begin
            @(negedge clk);
            d_start = 1'b0;
        end
        chk("pre_rst_class", int'(d_class_addr), 5);
        chk("pre_rst_pred", int'(d_pred), 3);
        chk("pre_rst_cmp", int'(d_cmp), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(d_busy), 0);
        chk("mid_rst_cmp", int'(d_cmp), 0);
        chk("mid_rst_inf", int'(d_inf), 0);
        chk("mid_rst_pred", int'(d_pred), 0);
        chk("mid_rst_best", int'(d_best), 0);
        chk("mid_rst_class", int'(d_class_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (d_done) nd++;
            if (d_busy) nd++;
        end
        chk("post_rst_no_done_or_busy", nd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
